// File: rtl/test_port_writer_pkg.sv
// Shared types and constants for the test-port writer and anything that checks its output.
package test_port_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BEGIN_WR = 3'd1,
        ST_GAP      = 3'd2,
        ST_DATA_WR  = 3'd3,
        ST_END_WR   = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [29:0] TEST_PORT    = 30'hFF;
    localparam logic [31:0] BEGIN_SYMBOL = 32'h0000_0168;
    localparam logic [31:0] END_SYMBOL   = 32'h0000_0D5D;

    localparam int CNT_W       = 7;
    localparam int STALL_CNT_W = 16;

    function automatic logic is_write_state(input state_t s);
        return (s == ST_BEGIN_WR) || (s == ST_DATA_WR) || (s == ST_END_WR);
    endfunction

endpackage

// File: rtl/test_port_writer_if.sv
// Result-stream input and test-port write bus of the writer, bundled as one interface.
interface test_port_writer_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        stall;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;

    modport master (
        input  in_valid, in_data, stall,
        output in_ready, addr, data, wen
    );

    modport slave (
        output in_valid, in_data, stall,
        input  in_ready, addr, data, wen
    );
endinterface

// File: rtl/test_port_writer_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/test_port_writer.sv
// Frames a run as BEGIN_SYMBOL, NUM_WORDS buffered results, END_SYMBOL, each a separate wen pulse.
// Define STALL_TIMEOUT_EN to abort a write stalled for 16'hFFFF cycles and flag it on timeout.
//
//   state    | meaning
//   IDLE     | waiting for start; input FIFO may fill
//   BEGIN_WR | writing BEGIN_SYMBOL, held while stalled
//   GAP      | one-or-more wen-low cycles; waits here for FIFO data
//   DATA_WR  | writing FIFO head, popped on the unstalled cycle
//   END_WR   | writing END_SYMBOL, held while stalled
//   DONE     | run finished; start re-arms
module test_port_writer
    import test_port_writer_pkg::*;
#(
    parameter int NUM_WORDS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    test_port_writer_if.master     bus,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       word_cnt
`ifdef STALL_TIMEOUT_EN
    ,
    output logic                   timeout
`endif
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS);

    state_t                    state, state_nxt;
    logic                      wen_c;
    logic [31:0]               data_c;
    logic [31:0]               data_q;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [31:0]               fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      cnt_inc;
    logic                      run_start;
    logic                      stall_expired;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (fifo_pop),
        .din   (bus.in_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef STALL_TIMEOUT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign stall_expired = is_write_state(state) && (stall_cnt == '1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (is_write_state(state) && bus.stall && !stall_expired)
                stall_cnt <= stall_cnt + 1'b1;
            else
                stall_cnt <= '0;
            if (run_start)          timeout <= 1'b0;
            else if (stall_expired) timeout <= 1'b1;
        end
    end
`else
    assign stall_expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        wen_c     = 1'b0;
        data_c    = data_q;
        fifo_pop  = 1'b0;
        cnt_inc   = 1'b0;
        run_start = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_BEGIN_WR;
                    run_start = 1'b1;
                end
            end
            ST_BEGIN_WR: begin
                wen_c  = 1'b1;
                data_c = BEGIN_SYMBOL;
                if (!bus.stall) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (word_cnt == LAST_CNT)  state_nxt = ST_END_WR;
                else if (fifo_count != '0) state_nxt = ST_DATA_WR;
            end
            ST_DATA_WR: begin
                wen_c  = 1'b1;
                data_c = fifo_head;
                // Never pop an empty buffer, even if the state were corrupted.
                if (!bus.stall && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_END_WR: begin
                wen_c  = 1'b1;
                data_c = END_SYMBOL;
                if (!bus.stall) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (stall_expired) begin
            state_nxt = ST_DONE;
            wen_c     = 1'b0;
            data_c    = data_q;
            fifo_pop  = 1'b0;
            cnt_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            data_q   <= '0;
        end else begin
            state <= state_nxt;
            if (run_start)    word_cnt <= '0;
            else if (cnt_inc) word_cnt <= word_cnt + 1'b1;
            if (wen_c) data_q <= data_c;
        end
    end

    assign bus.wen      = wen_c;
    assign bus.data     = data_c;
    assign bus.addr     = wen_c ? TEST_PORT : '0;
    assign bus.in_ready = !fifo_full;
    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign done         = (state == ST_DONE);
endmodule

// File: tb/tb_test_port_writer.sv
// Bench for test_port_writer: random producer/stall stimulus scored against a write-sequence model.
module tb_test_port_writer;
    import test_port_writer_pkg::*;

    localparam int NUM_WORDS  = 32;
    localparam int FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [CNT_W-1:0] word_cnt;
`ifdef STALL_TIMEOUT_EN
    logic             timeout;
`endif

    test_port_writer_if bus_if();

    test_port_writer #(
        .NUM_WORDS  (NUM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus_if),
        .busy     (busy),
        .done     (done),
        .word_cnt (word_cnt)
`ifdef STALL_TIMEOUT_EN
        ,
        .timeout  (timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    // producer control: 0 = idle, 1 = always valid, 2 = random valid
    int          prod_mode = 0;
    bit          use_fib = 1'b1;
    logic [31:0] fib_a = 32'd0;
    logic [31:0] fib_b = 32'd1;

    // model: words accepted by the FIFO, and the per-run write record
    logic [31:0] ref_q[$];
    logic [31:0] pulse_data[$];
    logic [31:0] exp_data[$];
    int          pulse_start[$];
    int          pulse_len[$];
    int          viol = 0;
    int          underflow = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bit hs;
        logic [31:0] t;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 32'd0;
        bus_if.stall    = 1'b0;
        forever begin
            @(negedge clk);
            hs = rst && bus_if.in_valid && bus_if.in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                if (use_fib) begin
                    t = fib_a + fib_b;
                    fib_a = fib_b;
                    fib_b = t;
                    bus_if.in_data = fib_a;
                end else begin
                    bus_if.in_data = $urandom;
                end
            end
            case (prod_mode)
                1:       bus_if.in_valid = 1'b1;
                2:       bus_if.in_valid = ($urandom_range(0, 3) != 0);
                default: bus_if.in_valid = 1'b0;
            endcase
        end
    end

    // Expected write order: BEGIN, then words in acceptance order, then END.
    initial begin
        bit prev_wen = 1'b0;
        int cur_len = 0;
        int idx;
        logic [31:0] cur_data = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) ref_q.delete();
            if (bus_if.wen && !prev_wen) begin
                idx = pulse_data.size();
                pulse_data.push_back(bus_if.data);
                pulse_start.push_back(cyc);
                cur_len  = 1;
                cur_data = bus_if.data;
                if (idx == 0) e = BEGIN_SYMBOL;
                else if (idx <= NUM_WORDS) begin
                    if (ref_q.size() > 0) e = ref_q.pop_front();
                    else begin
                        e = 32'hDEAD_BEEF;
                        underflow++;
                    end
                end else e = END_SYMBOL;
                exp_data.push_back(e);
            end else if (bus_if.wen) begin
                cur_len++;
                if (bus_if.data !== cur_data) viol++;
            end
            if (!bus_if.wen && prev_wen) pulse_len.push_back(cur_len);
            if (bus_if.wen ? (bus_if.addr !== TEST_PORT) : (bus_if.addr !== 30'd0)) viol++;
            if (rst && bus_if.in_valid && bus_if.in_ready) ref_q.push_back(bus_if.in_data);
            prev_wen = bus_if.wen;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        pulse_data.delete();
        exp_data.delete();
        pulse_start.delete();
        pulse_len.delete();
        viol = 0;
        underflow = 0;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic summarize(output int n_bad, output int first_bad);
        n_bad = 0;
        first_bad = -1;
        for (int i = 0; i < pulse_data.size(); i++) begin
            if (i >= exp_data.size() || pulse_data[i] !== exp_data[i]) begin
                n_bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (first_bad < 0) first_bad = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_if.wen !== 1'b0 || bus_if.addr !== 30'd0 || bus_if.data !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: wen=%b addr=%h data=%h, required 0/0/0", bus_if.wen, bus_if.addr, bus_if.data);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || word_cnt !== 7'd0 || bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b word_cnt=%0d in_ready=%b, required 0 0 0 1",
                     busy, done, word_cnt, bus_if.in_ready);
        end
`ifdef STALL_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout: got %b required 0", timeout);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_basic_run();
        logic [31:0] fib_ref [5] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
        int nb, fb, bad;
        bit ok;
        clear_obs();
        use_fib = 1'b1;
        prod_mode = 1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (bus_if.in_ready !== 1'b0 || ref_q.size() != FIFO_DEPTH) begin
            errors++;
            $display("FAIL fifo_full_idle: in_ready=%b accepted=%0d, required 0 and %0d",
                     bus_if.in_ready, ref_q.size(), FIFO_DEPTH);
        end
        do_start();
        use_fib = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus_if.wen !== 1'b1 || bus_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_until_pop: wen=%b in_ready=%b at first data write, required 1 0",
                     bus_if.wen, bus_if.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_if.in_ready !== 1'b1 || word_cnt !== 7'd1) begin
            errors++;
            $display("FAIL ready_after_pop: in_ready=%b word_cnt=%0d, required 1 1", bus_if.in_ready, word_cnt);
        end
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done: no done within budget, got 0 required 1");
        end
        summarize(nb, fb);
        checks++;
        if (pulse_data.size() != NUM_WORDS + 2 || nb != 0) begin
            errors++;
            $display("FAIL basic_data: pulses=%0d bad=%0d (idx %0d got %h), required %0d pulses 0 bad (expected %h)",
                     pulse_data.size(), nb, fb, pulse_data[fb], NUM_WORDS + 2, exp_data[fb]);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) if (pulse_data[i+1] !== fib_ref[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_fib: %0d of first 5 words differ from 0,1,1,2,3 (word1 got %h)", bad, pulse_data[1]);
        end
        bad = 0;
        for (int i = 0; i < pulse_start.size(); i++) if (pulse_start[i] != start_cyc + 1 + 2*i) bad++;
        checks++;
        if (bad != 0 || pulse_start.size() == 0) begin
            errors++;
            $display("FAIL basic_timing: %0d pulses off the start+1+2i grid (first at %0d), required start at %0d",
                     bad, pulse_start.size() > 0 ? pulse_start[0] : -1, start_cyc + 1);
        end
        checks++;
        if (viol + underflow != 0 || word_cnt !== 7'(NUM_WORDS) || done !== 1'b1 || busy !== 1'b0 || bus_if.wen !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: viol=%0d underflow=%0d word_cnt=%0d done=%b busy=%b wen=%b, required 0 0 %0d 1 0 0",
                     viol, underflow, word_cnt, done, busy, bus_if.wen, NUM_WORDS);
        end
    endtask

    task automatic test_stall();
        int nb, fb, bad;
        int si;
        bit found, ok;
        clear_obs();
        prod_mode = 1;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.wen === 1'b1 && word_cnt === 7'd4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stall_reach: word 5 write not seen, got 0 required 1");
        end
        bus_if.stall = 1'b1;
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus_if.wen !== 1'b1 || word_cnt !== 7'd4) bad++;
        end
        bus_if.stall = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d stalled cycles lost wen or moved word_cnt, required 0", bad);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.wen !== 1'b0 || word_cnt !== 7'd5) begin
            errors++;
            $display("FAIL stall_release: wen=%b word_cnt=%0d, required 0 5", bus_if.wen, word_cnt);
        end
        wait_done(300, ok);
        summarize(nb, fb);
        si = 5;
        checks++;
        if (!ok || pulse_data.size() != NUM_WORDS + 2 || nb != 0 || viol + underflow != 0) begin
            errors++;
            $display("FAIL stall_run: done=%b pulses=%0d bad=%0d viol=%0d underflow=%0d, required 1 %0d 0 0 0",
                     ok, pulse_data.size(), nb, viol, underflow, NUM_WORDS + 2);
        end
        checks++;
        if (pulse_len[si] != 4 || pulse_start[si+1] - pulse_start[si] != 5) begin
            errors++;
            $display("FAIL stall_shape: word5 len=%0d next pulse after %0d cycles, required 4 and 5",
                     pulse_len[si], pulse_start[si+1] - pulse_start[si]);
        end
    endtask

    task automatic test_starve();
        int nb, fb, bad;
        bit found, ok;
        logic [CNT_W-1:0] wc;
        clear_obs();
        prod_mode = 1;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (word_cnt === 7'd7) found = 1'b1;
        end
        prod_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (ref_q.size() == 0 && bus_if.wen === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL starve_drain: buffer never drained, got 0 required 1");
        end
        wc = word_cnt;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.wen !== 1'b0 || bus_if.addr !== 30'd0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || word_cnt !== wc || int'(word_cnt) != pulse_data.size() - 1) begin
            errors++;
            $display("FAIL starve_idle: bad cycles=%0d word_cnt=%0d, required 0 and %0d",
                     bad, word_cnt, pulse_data.size() - 1);
        end
        prod_mode = 2;
        wait_done(400, ok);
        summarize(nb, fb);
        checks++;
        if (!ok || pulse_data.size() != NUM_WORDS + 2 || nb != 0 || viol + underflow != 0) begin
            errors++;
            $display("FAIL starve_run: done=%b pulses=%0d bad=%0d viol=%0d underflow=%0d, required 1 %0d 0 0 0",
                     ok, pulse_data.size(), nb, viol, underflow, NUM_WORDS + 2);
        end
    endtask

    task automatic test_random_stall();
        int nb, fb, bad;
        bit ok;
        clear_obs();
        prod_mode = 2;
        do_start();
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            bus_if.stall = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            if (done === 1'b1) ok = 1'b1;
        end
        bus_if.stall = 1'b0;
        @(negedge clk);
        summarize(nb, fb);
        checks++;
        if (!ok || pulse_data.size() != NUM_WORDS + 2 || nb != 0) begin
            errors++;
            $display("FAIL random_run: done=%b pulses=%0d bad=%0d (idx %0d got %h expected %h), required 1 %0d 0",
                     ok, pulse_data.size(), nb, fb, pulse_data[fb], exp_data[fb], NUM_WORDS + 2);
        end
        bad = 0;
        for (int i = 1; i < pulse_start.size(); i++)
            if (pulse_start[i] - pulse_start[i-1] < pulse_len[i-1] + 1) bad++;
        checks++;
        if (bad != 0 || viol + underflow != 0 || word_cnt !== 7'(NUM_WORDS)) begin
            errors++;
            $display("FAIL random_protocol: gapless=%0d viol=%0d underflow=%0d word_cnt=%0d, required 0 0 0 %0d",
                     bad, viol, underflow, word_cnt, NUM_WORDS);
        end
    endtask

    task automatic test_reset_mid_run();
        int nb, fb;
        bit found, ok;
        clear_obs();
        prod_mode = 1;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.wen === 1'b1 && word_cnt === 7'd11) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrst_reach: word 12 write not seen, got 0 required 1");
        end
        rst = 1'b0;
        prod_mode = 0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.wen !== 1'b0 || word_cnt !== 7'd0 || busy !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: wen=%b word_cnt=%0d busy=%b in_ready=%b, required 0 0 0 1",
                     bus_if.wen, word_cnt, busy, bus_if.in_ready);
        end
        rst = 1'b1;
        clear_obs();
        do_start();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (pulse_data.size() != 1 || pulse_data[0] !== BEGIN_SYMBOL || bus_if.wen !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_empty: pulses=%0d first=%h wen=%b busy=%b, required 1 %h 0 1",
                     pulse_data.size(), pulse_data[0], bus_if.wen, busy, BEGIN_SYMBOL);
        end
        prod_mode = 1;
        wait_done(300, ok);
        summarize(nb, fb);
        checks++;
        if (!ok || pulse_data.size() != NUM_WORDS + 2 || nb != 0 || viol + underflow != 0) begin
            errors++;
            $display("FAIL midrst_replay: done=%b pulses=%0d bad=%0d viol=%0d underflow=%0d, required 1 %0d 0 0 0",
                     ok, pulse_data.size(), nb, viol, underflow, NUM_WORDS + 2);
        end
    endtask

`ifdef STALL_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        clear_obs();
        do_start();
        bus_if.stall = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 70000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || timeout !== 1'b1 || bus_if.wen !== 1'b0) begin
            errors++;
            $display("FAIL timeout: done=%b timeout=%b wen=%b, required 1 1 0", ok, timeout, bus_if.wen);
        end
        bus_if.stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_run();
        test_stall();
        test_starve();
        test_random_stall();
        test_reset_mid_run();
`ifdef STALL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
